poly_eval: RTL

- Pipelined piecewise-quadratic evaluator for the ICDF Gaussian generator. Computes y = (c2*x + c1)*x + c0 by Horner's rule, applies the sample sign and emits the signed Gaussian sample.
- Sits directly downstream of the registered coefficient ROM.
- Receives x, sign and valid in the same cycle the segment index is presented to the ROM, and aligns them internally with the ROM's 1-cycle registered output.

---
 rtl/poly_eval_if.sv | 28 ++
 rtl/poly_eval.sv | 120 ++++++++++++
 2 files changed

// File: rtl/poly_eval_if.sv
// Sample/coefficient bus into the Horner evaluator and the signed sample bus out of it.
// The master drives the segment-aligned sample and the ROM coefficients; the slave returns samples.
interface poly_eval_if #(
    parameter int X_W   = 18,
    parameter int C0_W  = 21,
    parameter int C12_W = 18,
    parameter int OUT_W = 22
);
    logic                    en;
    logic                    valid_in;
    logic                    sign_in;
    logic [X_W-1:0]          x_in;
    logic signed [C0_W-1:0]  coef0;
    logic signed [C12_W-1:0] coef1;
    logic signed [C12_W-1:0] coef2;
    logic                    valid_out;
    logic signed [OUT_W-1:0] y_out;

    modport master (
        output en, valid_in, sign_in, x_in, coef0, coef1, coef2,
        input  valid_out, y_out
    );

    modport slave (
        input  en, valid_in, sign_in, x_in, coef0, coef1, coef2,
        output valid_out, y_out
    );
endinterface

// File: rtl/poly_eval.sv
// Piecewise-quadratic Horner evaluator y = (c2*x + c1)*x + c0 with sign apply; GRNG_ROUND_EN selects round-to-nearest shifts.
// Latency: 6 cycles from valid_in/x_in to valid_out/y_out (coefficients arrive 1 cycle after x from the registered ROM).
// Backpressure: none; free-running, one sample per clock, valid tag travels alongside the data.
module poly_eval #(
    parameter int X_W   = 18,
    parameter int C0_W  = 21,
    parameter int C12_W = 18,
    parameter int OUT_W = 22
) (
    input logic        clk,
    input logic        rst,
    poly_eval_if.slave bus
);

    localparam int P1_W = C12_W + X_W + 1;
    localparam int S1_W = C12_W + 1;
    localparam int P2_W = S1_W + X_W + 1;
    localparam int T2_W = C12_W + 2;

`ifdef GRNG_ROUND_EN
    localparam logic RND = 1'b1;
`else
    localparam logic RND = 1'b0;
`endif

    // Half-LSB bias ahead of the arithmetic shift gives round-to-nearest, ties toward +inf.
    localparam logic signed [P1_W-1:0] BIAS1 = P1_W'(RND) << (X_W - 1);
    localparam logic signed [P2_W-1:0] BIAS2 = P2_W'(RND) << (X_W - 1);

    localparam logic signed [OUT_W-1:0] Y_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] Y_MAX = {1'b0, {(OUT_W-1){1'b1}}};

    logic [X_W-1:0]          x_a, x_1, x_2;
    logic                    sign_a, sign_1, sign_2, sign_3, sign_4;
    logic                    v_a, v_1, v_2, v_3, v_4, v_q;
    logic signed [C12_W-1:0] t1, coef1_d;
    logic signed [C0_W-1:0]  coef0_d1, coef0_d2, coef0_d3;
    logic signed [S1_W-1:0]  s1;
    logic signed [T2_W-1:0]  t2;
    logic signed [OUT_W-1:0] y4, y_q;

    logic signed [P1_W-1:0]  p1;
    logic signed [P2_W-1:0]  p2;
    logic signed [C12_W-1:0] t1_n;
    logic signed [S1_W-1:0]  s1_n;
    logic signed [T2_W-1:0]  t2_n;
    logic signed [OUT_W-1:0] y_n, y_neg;

    always_comb begin
        p1    = P1_W'(bus.coef2) * P1_W'($signed({1'b0, x_a}));
        t1_n  = C12_W'((p1 + BIAS1) >>> X_W);
        s1_n  = S1_W'(t1) + S1_W'(coef1_d);
        p2    = P2_W'(s1) * P2_W'($signed({1'b0, x_2}));
        t2_n  = T2_W'((p2 + BIAS2) >>> X_W);
        y_n   = OUT_W'(t2) + OUT_W'(coef0_d3);
        y_neg = (y4 == Y_MIN) ? Y_MAX : -y4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_a      <= '0;
            sign_a   <= 1'b0;
            v_a      <= 1'b0;
            t1       <= '0;
            coef1_d  <= '0;
            coef0_d1 <= '0;
            x_1      <= '0;
            sign_1   <= 1'b0;
            v_1      <= 1'b0;
            s1       <= '0;
            coef0_d2 <= '0;
            x_2      <= '0;
            sign_2   <= 1'b0;
            v_2      <= 1'b0;
            t2       <= '0;
            coef0_d3 <= '0;
            sign_3   <= 1'b0;
            v_3      <= 1'b0;
            y4       <= '0;
            sign_4   <= 1'b0;
            v_4      <= 1'b0;
            y_q      <= '0;
            v_q      <= 1'b0;
        end else begin
            // Align x/sign/valid with the ROM's registered coefficient output.
            x_a      <= bus.x_in;
            sign_a   <= bus.sign_in;
            v_a      <= bus.valid_in & bus.en;

            t1       <= t1_n;
            coef1_d  <= bus.coef1;
            coef0_d1 <= bus.coef0;
            x_1      <= x_a;
            sign_1   <= sign_a;
            v_1      <= v_a;

            s1       <= s1_n;
            coef0_d2 <= coef0_d1;
            x_2      <= x_1;
            sign_2   <= sign_1;
            v_2      <= v_1;

            t2       <= t2_n;
            coef0_d3 <= coef0_d2;
            sign_3   <= sign_2;
            v_3      <= v_2;

            y4       <= y_n;
            sign_4   <= sign_3;
            v_4      <= v_3;

            y_q      <= sign_4 ? y_neg : y4;
            v_q      <= v_4;
        end
    end

    assign bus.valid_out = v_q;
    assign bus.y_out     = y_q;

endmodule
